lsu_param: RTL and testbench

Parametrised load/store unit for the pipeline's memory stage. It decodes a 32-bit address into three targets: on-chip data memory, the output peripheral registers (LEDs, seven-segment, LCD), and the synchronised switch input. It performs byte, halfword and word loads and stores with RISC-V extension rules, using a request/acknowledge handshake with one-cycle latency. Compared with the fixed LSU, this block adds a configurable memory depth, a configurable seven-segment digit count, a configurable switch synchroniser, byte-enable stores and misalignment error reporting.

---
 rtl/lsu_param.sv | 191 +++++++++++++++++++
 tb/tb_lsu_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_param.sv
// Load/store unit for the memory stage: data memory, output peripherals and switch input,
// byte/half/word accesses with a one-cycle request/acknowledge handshake.
module lsu_param #(
    parameter int DMEM_WORDS = 512,
    parameter int NUM_HEX    = 8,
    parameter int SW_SYNC    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_req,
    input  logic                   i_lsu_wren,
    input  logic [2:0]             slt_sl,
    input  logic [31:0]            i_lsu_addr,
    input  logic [31:0]            i_st_data,
    output logic                   o_busy,
    output logic                   o_ack,
    output logic                   o_err,
    output logic [31:0]            o_ld_data,
    output logic [31:0]            o_io_ledr,
    output logic [31:0]            o_io_ledg,
    output logic [31:0]            o_io_lcd,
    output logic [7*NUM_HEX-1:0]   o_io_hex,
    input  logic [31:0]            i_io_sw
);
    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_LBU = 3'b110;
    localparam logic [2:0] OP_LHU = 3'b111;

    typedef enum logic {IDLE, ACK} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t        state;
    size_t         acc_size;
    logic          misaligned, accept, do_store;
    logic          hit_dmem, sel_red, sel_green, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw;
    logic [19:0]   page;
    logic [3:0]    be;
    logic [31:0]   wdata, io_rdata;
    logic [AW-1:0] dmem_idx;

    logic [31:0]   dmem [DMEM_WORDS];
    logic [31:0]   dmem_q, io_q, rd_word;
    logic [31:0]   ledr, ledg, hex_lo, hex_hi, lcd;
    logic [31:0]   sw_sync [SW_SYNC];
    logic [1:0]    lane_q;
    logic [2:0]    slt_q;
    logic          wren_q, err_q, tgt_dmem_q;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    always_comb begin
        case (slt_sl)
            3'b000, 3'b011, 3'b110: acc_size = SZ_B;
            3'b001, 3'b100, 3'b111: acc_size = SZ_H;
            default:                acc_size = SZ_W;
        endcase
    end

    // Alignment is judged before decode, so a misaligned access never touches any target.
    assign misaligned = ((acc_size == SZ_H) && i_lsu_addr[0]) ||
                        ((acc_size == SZ_W) && (i_lsu_addr[1:0] != 2'b00));
    assign accept     = (state == IDLE) && i_req;
    assign do_store   = accept && i_lsu_wren && !misaligned;

    assign page       = i_lsu_addr[31:12];
    assign hit_dmem   = i_lsu_addr < DMEM_BYTES;
    assign sel_red    = page == 20'h10000;
    assign sel_green  = page == 20'h10001;
    assign sel_hex_lo = page == 20'h10002;
    assign sel_hex_hi = page == 20'h10003;
    assign sel_lcd    = page == 20'h10004;
    assign sel_sw     = page == 20'h10010;
    assign dmem_idx   = i_lsu_addr[AW+1:2];

    always_comb begin
        be    = 4'b1111;
        wdata = i_st_data;
        case (acc_size)
            SZ_B: begin
                be    = 4'b0001 << i_lsu_addr[1:0];
                wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        io_rdata = '0;
        if (sel_red)         io_rdata = ledr;
        else if (sel_green)  io_rdata = ledg;
        else if (sel_hex_lo) io_rdata = hex_lo;
        else if (sel_hex_hi) io_rdata = hex_hi;
        else if (sel_lcd)    io_rdata = lcd;
        else if (sel_sw)     io_rdata = sw_sync[SW_SYNC-1];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            lane_q     <= '0;
            slt_q      <= '0;
            wren_q     <= 1'b0;
            err_q      <= 1'b0;
            tgt_dmem_q <= 1'b0;
            io_q       <= '0;
            ledr       <= '0;
            ledg       <= '0;
            hex_lo     <= '0;
            hex_hi     <= '0;
            lcd        <= '0;
        end else begin
            if (state == IDLE) begin
                if (i_req) begin
                    state      <= ACK;
                    lane_q     <= i_lsu_addr[1:0];
                    slt_q      <= slt_sl;
                    wren_q     <= i_lsu_wren;
                    err_q      <= misaligned;
                    tgt_dmem_q <= hit_dmem;
                    io_q       <= io_rdata;
                end
            end else begin
                state <= IDLE;
            end
            for (int b = 0; b < 4; b++) begin
                if (do_store && be[b]) begin
                    if (sel_red)    ledr[8*b +: 8]   <= wdata[8*b +: 8];
                    if (sel_green)  ledg[8*b +: 8]   <= wdata[8*b +: 8];
                    if (sel_hex_lo) hex_lo[8*b +: 8] <= wdata[8*b +: 8];
                    if (sel_hex_hi) hex_hi[8*b +: 8] <= wdata[8*b +: 8];
                    if (sel_lcd)    lcd[8*b +: 8]    <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Block RAM with byte enables; no reset so it maps onto memory primitives.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (do_store && hit_dmem && be[b]) dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (accept) dmem_q <= dmem[dmem_idx];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < SW_SYNC; s++) sw_sync[s] <= '0;
        end else begin
            sw_sync[0] <= i_io_sw;
            for (int s = 1; s < SW_SYNC; s++) sw_sync[s] <= sw_sync[s-1];
        end
    end

    assign rd_word  = tgt_dmem_q ? dmem_q : io_q;
    assign byte_sel = rd_word[8*lane_q +: 8];
    assign half_sel = rd_word[16*lane_q[1] +: 16];

    always_comb begin
        case (slt_q)
            OP_LB:   o_ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LH:   o_ld_data = {{16{half_sel[15]}}, half_sel};
            OP_LBU:  o_ld_data = {24'h0, byte_sel};
            OP_LHU:  o_ld_data = {16'h0, half_sel};
            default: o_ld_data = rd_word;
        endcase
        if ((state != ACK) || err_q || wren_q) o_ld_data = '0;
    end

    assign o_ack     = state == ACK;
    assign o_busy    = state == ACK;
    assign o_err     = (state == ACK) && err_q;
    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        if (i < 4) begin : g_lo
            assign o_io_hex[7*i +: 7] = hex_lo[8*i +: 7];
        end else begin : g_hi
            assign o_io_hex[7*i +: 7] = hex_hi[8*(i-4) +: 7];
        end
    end
endmodule

// File: tb/tb_lsu_param.sv
// Randomised and directed bench for lsu_param against a byte-addressed reference model.
module tb_lsu_param;
    localparam int DMEM_WORDS = 512;
    localparam int SW_SYNC    = 2;
    localparam int DMEM_BYTES = 4 * DMEM_WORDS;

    logic        clock = 1'b0;
    logic        resetN, req, wren;
    logic [2:0]  slt;
    logic [31:0] addr, stData, ioSw;
    logic        busy, ack, err, d2Busy, d2Ack, d2Err;
    logic [31:0] ldData, ledr, ledg, lcd, d2Ld, d2Ledr, d2Ledg, d2Lcd;
    logic [55:0] hex;
    logic [13:0] hex2;

    logic [7:0]  memModel [DMEM_BYTES];
    logic [31:0] pregModel [5];
    logic [31:0] swModel;
    int          total = 0;
    int          bad = 0;

    lsu_param #(.DMEM_WORDS(DMEM_WORDS), .NUM_HEX(8), .SW_SYNC(SW_SYNC)) u_dut (
        .i_clk(clock), .i_reset_n(resetN), .i_req(req), .i_lsu_wren(wren), .slt_sl(slt),
        .i_lsu_addr(addr), .i_st_data(stData), .o_busy(busy), .o_ack(ack), .o_err(err),
        .o_ld_data(ldData), .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd),
        .o_io_hex(hex), .i_io_sw(ioSw)
    );

    lsu_param #(.DMEM_WORDS(DMEM_WORDS), .NUM_HEX(2), .SW_SYNC(SW_SYNC)) u_dut2 (
        .i_clk(clock), .i_reset_n(resetN), .i_req(req), .i_lsu_wren(wren), .slt_sl(slt),
        .i_lsu_addr(addr), .i_st_data(stData), .o_busy(d2Busy), .o_ack(d2Ack), .o_err(d2Err),
        .o_ld_data(d2Ld), .o_io_ledr(d2Ledr), .o_io_ledg(d2Ledg), .o_io_lcd(d2Lcd),
        .o_io_hex(hex2), .i_io_sw(ioSw)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Peripheral index 0..4 = red, green, hex_lo, hex_hi, lcd; -1 when not a peripheral.
    function automatic int periphIndex(input logic [31:0] a);
        if ((a >> 12) >= 32'h10000 && (a >> 12) <= 32'h10004) return int'((a >> 12) - 32'h10000);
        return -1;
    endfunction

    function automatic logic [7:0] readByte(input logic [31:0] a);
        int p;
        p = periphIndex(a);
        if (a < DMEM_BYTES) return memModel[a];
        if (p >= 0) return pregModel[p][8*a[1:0] +: 8];
        if ((a >> 12) == 32'h10010) return swModel[8*a[1:0] +: 8];
        return 8'h00;
    endfunction

    function automatic void writeByte(input logic [31:0] a, input logic [7:0] b);
        int p;
        p = periphIndex(a);
        if (a < DMEM_BYTES) memModel[a] = b;
        else if (p >= 0) pregModel[p][8*a[1:0] +: 8] = b;
    endfunction

    function automatic void modelAccess(input bit w, input logic [2:0] t, input logic [31:0] a,
                                        input logic [31:0] d, output bit e, output logic [31:0] ld);
        int size;
        logic [31:0] v;
        size = (t == 3'd0 || t == 3'd3 || t == 3'd6) ? 1 :
               (t == 3'd1 || t == 3'd4 || t == 3'd7) ? 2 : 4;
        e  = (a % size) != 0;
        ld = '0;
        if (e) return;
        if (w) begin
            for (int k = 0; k < size; k++) writeByte(a + k, 8'(d >> (8 * k)));
        end else begin
            v = '0;
            for (int k = 0; k < size; k++) v = v | (32'(readByte(a + k)) << (8 * k));
            if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
            if (t == 3'd4 && v[15]) v = v | 32'hFFFF_0000;
            ld = v;
        end
    endfunction

    function automatic logic [55:0] expHex();
        logic [55:0] h;
        h = '0;
        for (int i = 0; i < 8; i++) h[7*i +: 7] = pregModel[(i < 4) ? 2 : 3][8*(i % 4) +: 7];
        return h;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkIo(input string tag);
        logic [55:0] h;
        h = expHex();
        checkOutput({tag, ".ledr"}, 64'(ledr), 64'(pregModel[0]));
        checkOutput({tag, ".ledg"}, 64'(ledg), 64'(pregModel[1]));
        checkOutput({tag, ".lcd"},  64'(lcd),  64'(pregModel[4]));
        checkOutput({tag, ".hex"},  64'(hex),  64'(h));
        checkOutput({tag, ".hex2"}, 64'(hex2), 64'(h[13:0]));
        checkOutput({tag, ".ledr2"}, 64'(d2Ledr), 64'(pregModel[0]));
        checkOutput({tag, ".ledg2"}, 64'(d2Ledg), 64'(pregModel[1]));
        checkOutput({tag, ".lcd2"},  64'(d2Lcd),  64'(pregModel[4]));
    endtask

    // One complete access: drive for the accept edge, scramble inputs after it, check the ACK cycle.
    task automatic applyStimulus(input string tag, input bit w, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] d);
        bit          expErr;
        logic [31:0] expLd;
        @(negedge clock);
        wren = w; slt = t; addr = a; stData = d; req = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0; wren = ~w; slt = 3'($urandom); addr = $urandom; stData = $urandom;
        modelAccess(w, t, a, d, expErr, expLd);
        @(negedge clock);
        checkOutput({tag, ".ack"},  64'(ack),    64'd1);
        checkOutput({tag, ".busy"}, 64'(busy),   64'd1);
        checkOutput({tag, ".err"},  64'(err),    64'(expErr));
        checkOutput({tag, ".ld"},   64'(ldData), 64'(expLd));
        checkOutput({tag, ".ack2"}, 64'({d2Ack, d2Busy, d2Err}), 64'({2'b11, expErr}));
        checkOutput({tag, ".ld2"},  64'(d2Ld),   64'(expLd));
        checkIo(tag);
    endtask

    initial begin
        bit          e;
        logic [31:0] expLd, a;
        logic [2:0]  t;
        bit          w;

        resetN = 1'b0; req = 1'b0; wren = 1'b0; slt = '0; addr = '0; stData = '0; ioSw = '0;
        swModel = '0;
        for (int i = 0; i < 5; i++) pregModel[i] = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset.ack",  64'(ack),    64'd0);
        checkOutput("reset.busy", 64'(busy),   64'd0);
        checkOutput("reset.err",  64'(err),    64'd0);
        checkOutput("reset.ld",   64'(ldData), 64'd0);
        checkIo("reset");
        resetN = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 16; i++) applyStimulus("init", 1'b1, 3'b010, 32'(4 * i), $urandom);

        applyStimulus("sw10",  1'b1, 3'b010, 32'h10, 32'h1234_5678);
        applyStimulus("lw10",  1'b0, 3'b101, 32'h10, 32'h0);
        applyStimulus("lb13",  1'b0, 3'b011, 32'h13, 32'h0);
        applyStimulus("lh12",  1'b0, 3'b100, 32'h12, 32'h0);
        applyStimulus("sw20",  1'b1, 3'b010, 32'h20, 32'h0);
        applyStimulus("sb21",  1'b1, 3'b000, 32'h21, 32'hFFFF_FF80);
        applyStimulus("lb21",  1'b0, 3'b011, 32'h21, 32'h0);
        applyStimulus("lbu21", 1'b0, 3'b110, 32'h21, 32'h0);
        applyStimulus("lw20",  1'b0, 3'b101, 32'h20, 32'h0);

        applyStimulus("hexlo", 1'b1, 3'b010, 32'h1000_2000, 32'h7F06_5B4F);
        checkOutput("hex.digits",  64'(hex[27:0]), 64'({7'h7F, 7'h06, 7'h5B, 7'h4F}));
        checkOutput("hex2.digits", 64'(hex2),      64'({7'h5B, 7'h4F}));
        applyStimulus("hexhi", 1'b1, 3'b001, 32'h1000_3002, 32'h0000_3F66);

        @(negedge clock);
        ioSw = 32'hA5A5_0001;
        repeat (SW_SYNC + 1) @(negedge clock);
        swModel = ioSw;
        applyStimulus("swld",  1'b0, 3'b101, 32'h1001_0000, 32'h0);
        applyStimulus("swst",  1'b1, 3'b010, 32'h1001_0000, 32'hFFFF_FFFF);
        applyStimulus("swld2", 1'b0, 3'b101, 32'h1001_0000, 32'h0);

        applyStimulus("ledr",   1'b1, 3'b010, 32'h1000_0000, 32'h0000_BEEF);
        applyStimulus("misLh",  1'b0, 3'b100, 32'h1000_0001, 32'h0);
        applyStimulus("misLw",  1'b0, 3'b101, 32'h0000_0002, 32'h0);
        applyStimulus("misSw",  1'b1, 3'b010, 32'h1000_0002, 32'h1111_1111);
        applyStimulus("misSh",  1'b1, 3'b001, 32'h1000_0003, 32'h2222_2222);
        applyStimulus("ledrLw", 1'b0, 3'b101, 32'h1000_0000, 32'h0);

        // Held request: accepts on alternate edges, ld_data only during ACK.
        @(negedge clock);
        wren = 1'b0; slt = 3'b101; addr = 32'h10; stData = '0; req = 1'b1;
        modelAccess(1'b0, 3'b101, 32'h10, 32'h0, e, expLd);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checkOutput($sformatf("held%0d.ack", k), 64'(ack),    64'((k % 2) == 0));
            checkOutput($sformatf("held%0d.ld", k),  64'(ldData), 64'(((k % 2) == 0) ? expLd : 32'h0));
        end
        req = 1'b0;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clock);
                ioSw = $urandom;
                repeat (SW_SYNC + 1) @(negedge clock);
                swModel = ioSw;
            end
            w = 1'($urandom);
            t = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            case ($urandom_range(0, 7))
                0, 1:    a = 32'($urandom_range(0, 63));
                2:       a = 32'h1000_0000 | (32'($urandom_range(0, 4)) << 12) | 32'($urandom_range(0, 15));
                3:       a = 32'h1000_2000 | 32'($urandom_range(0, 7));
                4:       a = 32'h1000_3000 | 32'($urandom_range(0, 7));
                5:       a = 32'h1001_0000 | 32'($urandom_range(0, 7));
                6:       a = 32'h0000_0800 + 32'($urandom_range(0, 255));
                default: a = 32'h1000_5000 | 32'($urandom_range(0, 255));
            endcase
            applyStimulus($sformatf("rnd%0d", n), w, t, a, $urandom);
        end

        // Reset during the ACK of a DMEM store: no ack, IO cleared, memory write kept.
        applyStimulus("preRst", 1'b1, 3'b010, 32'h1000_4000, 32'h0BAD_F00D);
        @(negedge clock);
        wren = 1'b1; slt = 3'b010; addr = 32'h30; stData = 32'hCAFE_F00D; req = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0;
        modelAccess(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, e, expLd);
        checkOutput("rst.ackBefore", 64'(ack), 64'd1);
        resetN = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) pregModel[i] = '0;
        checkOutput("rst.ack",  64'(ack),    64'd0);
        checkOutput("rst.busy", 64'(busy),   64'd0);
        checkOutput("rst.ld",   64'(ldData), 64'd0);
        checkIo("rst");
        @(negedge clock);
        resetN = 1'b1;
        repeat (SW_SYNC + 1) @(negedge clock);
        applyStimulus("rst.dmem", 1'b0, 3'b101, 32'h30, 32'h0);
        applyStimulus("rst.ledr", 1'b0, 3'b101, 32'h1000_0000, 32'h0);
        applyStimulus("rst.sw",   1'b0, 3'b101, 32'h1001_0000, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
